// File: rtl/main_operand_buffer.sv
// Operand buffer for the CNN MAC array: unpacks a typed, packed load stream into
// ifm/weight windows plus a bias, and hands out complete sets under valid/ready.
module main_operand_buffer #(
  parameter int IN_W   = 32,
  parameter int DATA_W = 8,
  parameter int KERNEL = 3,
  parameter int BIAS_W = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [1:0]                             in_sel,
  input  logic [IN_W-1:0]                        in_data,
  input  logic                                   wgt_hold,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [KERNEL*KERNEL*DATA_W-1:0] out_ifm,
  output logic signed [KERNEL*KERNEL*DATA_W-1:0] out_wgt,
  output logic signed [BIAS_W-1:0]               out_bias,
  output logic                                   err
);

  localparam int NUM   = KERNEL * KERNEL;
  localparam int LANES = IN_W / DATA_W;
  localparam int WORDS = (NUM + LANES - 1) / LANES;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [CW-1:0] ifm_cnt, wgt_cnt;
  logic          ifm_full, wgt_full, bias_full;
  logic          ifm_full_n, wgt_full_n, bias_full_n;
  logic          sel_full, accept, consume;
  logic          ld_ifm, ld_wgt, ld_bias, ld_bad;

  // Reserved selector always accepts so a bad word can never wedge the stream.
  always_comb begin
    sel_full = 1'b0;
    case (in_sel)
      2'd0:    sel_full = ifm_full;
      2'd1:    sel_full = wgt_full;
      2'd2:    sel_full = bias_full;
      default: sel_full = 1'b0;
    endcase
  end

  assign in_ready = !sel_full;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign ld_ifm   = accept && (in_sel == 2'd0);
  assign ld_wgt   = accept && (in_sel == 2'd1);
  assign ld_bias  = accept && (in_sel == 2'd2);
  assign ld_bad   = accept && (in_sel == 2'd3);

  // A load never targets a full buffer, so set and clear cannot collide.
  always_comb begin
    ifm_full_n  = ifm_full;
    wgt_full_n  = wgt_full;
    bias_full_n = bias_full;
    if (consume) begin
      ifm_full_n = 1'b0;
      if (!wgt_hold) begin
        wgt_full_n  = 1'b0;
        bias_full_n = 1'b0;
      end
    end
    if (ld_ifm && (ifm_cnt == LAST)) ifm_full_n = 1'b1;
    if (ld_wgt && (wgt_cnt == LAST)) wgt_full_n = 1'b1;
    if (ld_bias)                     bias_full_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_cnt   <= '0;
      wgt_cnt   <= '0;
      ifm_full  <= 1'b0;
      wgt_full  <= 1'b0;
      bias_full <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      ifm_full  <= ifm_full_n;
      wgt_full  <= wgt_full_n;
      bias_full <= bias_full_n;
      out_valid <= ifm_full_n & wgt_full_n & bias_full_n;
      if (ld_ifm) ifm_cnt <= (ifm_cnt == LAST) ? '0 : ifm_cnt + 1'b1;
      if (ld_wgt) wgt_cnt <= (wgt_cnt == LAST) ? '0 : wgt_cnt + 1'b1;
      if (ld_bad) err <= 1'b1;
    end
  end

  // Element e lives in word e/LANES, lane e%LANES; surplus lanes of the last word fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ifm  <= '0;
      out_wgt  <= '0;
      out_bias <= '0;
    end else begin
      for (int e = 0; e < NUM; e++) begin
        if (ld_ifm && (ifm_cnt == CW'(e / LANES)))
          out_ifm[e*DATA_W +: DATA_W] <= in_data[(e % LANES)*DATA_W +: DATA_W];
        if (ld_wgt && (wgt_cnt == CW'(e / LANES)))
          out_wgt[e*DATA_W +: DATA_W] <= in_data[(e % LANES)*DATA_W +: DATA_W];
      end
      if (ld_bias) out_bias <= in_data[BIAS_W-1:0];
    end
  end

endmodule
